seg_value_encoder: RTL and testbench

//  Upstream feeder of the multiplexed 7-segment display driver. Takes a binary value
//  and converts it to BCD with a sequential double-dabble engine. Each BCD digit is

---
 rtl/seg_pkg.sv | 34 +++
 rtl/seg_value_encoder_if.sv | 33 +++
 rtl/bin2bcd_seq.sv | 61 ++++++
 rtl/seg_value_encoder.sv | 149 ++++++++++++++
 tb/tb_seg_value_encoder.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared types, glyph constants, FSM encoding and digit-to-glyph lookup
// for the seven-segment value encoder.
package seg_pkg;

  // Glyph bit order is {dp,g,f,e,d,c,b,a}, 1 = segment lit
  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK = 8'h00;
  localparam seg_t SEG_DASH  = 8'h40;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // BCD digit to glyph; a nibble above 9 is not a digit and shows blank
  function automatic seg_t digit_to_seg(input logic [3:0] digit);
    case (digit)
      4'd0:    return 8'h3F;
      4'd1:    return 8'h06;
      4'd2:    return 8'h5B;
      4'd3:    return 8'h4F;
      4'd4:    return 8'h66;
      4'd5:    return 8'h6D;
      4'd6:    return 8'h7D;
      4'd7:    return 8'h07;
      4'd8:    return 8'h7F;
      4'd9:    return 8'h6F;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_value_encoder_if.sv
// Load/status/display bundle between a value source and seg_value_encoder.
// master = value source (drives value_i/load_i), slave = encoder.
interface seg_value_encoder_if #(
  parameter int SEG_CNT = 4,
  parameter int VALUE_W = 14
);

  logic [VALUE_W-1:0]      value_i;
  logic                    load_i;
  logic                    busy_o;
  logic                    done_o;
  logic [SEG_CNT-1:0]      en_o;
  logic [SEG_CNT-1:0][7:0] seg_o;

  modport master (
    output value_i,
    output load_i,
    input  busy_o,
    input  done_o,
    input  en_o,
    input  seg_o
  );

  modport slave (
    input  value_i,
    input  load_i,
    output busy_o,
    output done_o,
    output en_o,
    output seg_o
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// start_i is taken only while idle. bcd_valid_o is high during the cycle
// whose closing edge performs the final step, so bcd_o is final from the
// following cycle and holds until the next start.
module bin2bcd_seq #(
  parameter int VALUE_W = 14,
  parameter int DIG_CNT = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   start_i,
  input  logic [VALUE_W-1:0]     value_i,
  output logic                   busy_o,
  output logic                   bcd_valid_o,
  output logic [4*DIG_CNT-1:0]   bcd_o
);

  localparam int BCD_W = 4 * DIG_CNT;
  localparam int SR_W  = BCD_W + VALUE_W;
  localparam int CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;

  logic [SR_W-1:0]  r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [SR_W-1:0]  w_sr_adj;

  // Add-3 correction on every BCD nibble that would overflow when doubled
  always_comb begin
    w_sr_adj = r_sr;
    for (int d = 0; d < DIG_CNT; d++) begin
      if (r_sr[VALUE_W + 4*d +: 4] >= 4'd5) begin
        w_sr_adj[VALUE_W + 4*d +: 4] = r_sr[VALUE_W + 4*d +: 4] + 4'd3;
      end
    end
  end

  // Load on start, then correct-and-shift once per cycle until the counter expires
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start_i && !r_busy) begin
      r_sr   <= {{BCD_W{1'b0}}, value_i};
      r_cnt  <= CNT_W'(VALUE_W - 1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      // Bits leaving the top of the register are intentionally dropped
      r_sr  <= w_sr_adj << 1;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign busy_o      = r_busy;
  assign bcd_valid_o = r_busy && (r_cnt == '0);
  assign bcd_o       = r_sr[SR_W-1 -: BCD_W];

endmodule

// File: rtl/seg_value_encoder.sv
// Binary value to seven-segment glyph encoder feeding the display mux.
// Converts via bin2bcd_seq, flags values that do not fit the display,
// encodes glyphs and registers en_o/seg_o only when a conversion completes.
// Build option: define SEG_LEADING_ZERO_BLANK_EN to blank digits above the
// most significant nonzero digit (digit 0 always stays lit).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for load_i; display holds the last result
//   ST_CONV  | double-dabble steps running in bin2bcd_seq
//   ST_LATCH | BCD final; glyphs/enables registered at the closing edge
module seg_value_encoder
  import seg_pkg::*;
#(
  parameter int SEG_CNT = 4,
  parameter int VALUE_W = 14
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  seg_value_encoder_if.slave  bus
);

  localparam int unsigned MAX_VAL = 10**SEG_CNT - 1;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_ovf;
  logic                    r_done;
  logic [SEG_CNT-1:0]      r_en;
  logic [SEG_CNT-1:0][7:0] r_seg;

  logic                    w_load_acc;
  logic                    w_ovf_in;
  logic                    w_busy;
  logic                    w_start;
  logic                    w_latch;
  logic                    w_bin_busy;
  logic                    w_bcd_valid;
  logic [4*SEG_CNT-1:0]    w_bcd;
  logic [SEG_CNT-1:0]      w_en_nxt;
  logic [SEG_CNT-1:0][7:0] w_seg_nxt;

  assign w_load_acc = (r_state == ST_IDLE) && bus.load_i;
  assign w_ovf_in   = 32'(bus.value_i) > MAX_VAL;

  bin2bcd_seq #(
    .VALUE_W (VALUE_W),
    .DIG_CNT (SEG_CNT)
  ) u_bin2bcd (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (w_start),
    .value_i     (bus.value_i),
    .busy_o      (w_bin_busy),
    .bcd_valid_o (w_bcd_valid),
    .bcd_o       (w_bcd)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.load_i) w_state_nxt = ST_CONV;
      end
      ST_CONV: begin
        // Converter idle while we think it runs can only follow a glitch; resync
        if (!w_bin_busy)      w_state_nxt = ST_IDLE;
        else if (w_bcd_valid) w_state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    w_busy  = (r_state != ST_IDLE);
    w_start = w_load_acc;
    w_latch = (r_state == ST_LATCH);
  end

  // Overflow is decided from the loaded value and held for the whole conversion
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ovf <= 1'b0;
    end else if (w_load_acc) begin
      r_ovf <= w_ovf_in;
    end
  end

  // Glyph encoding, leading-zero handling and overflow dashes
  always_comb begin
    logic w_seen;
    w_en_nxt  = '1;
    w_seg_nxt = '0;
    w_seen    = 1'b0;
    if (r_ovf) begin
      for (int d = 0; d < SEG_CNT; d++) begin
        w_seg_nxt[d] = SEG_DASH;
      end
    end else begin
      for (int d = SEG_CNT - 1; d >= 0; d--) begin
        w_seg_nxt[d] = digit_to_seg(w_bcd[4*d +: 4]);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if ((w_bcd[4*d +: 4] != 4'd0) || (d == 0)) w_seen = 1'b1;
        w_en_nxt[d] = w_seen;
        if (!w_seen) w_seg_nxt[d] = SEG_BLANK;
`else
        w_seen = 1'b1;
`endif
      end
    end
  end

  // Display registers change only at LATCH so a partial conversion is never shown
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_en   <= '0;
      r_seg  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_latch;
      if (w_latch) begin
        r_en  <= w_en_nxt;
        r_seg <= w_seg_nxt;
      end
    end
  end

  assign bus.busy_o = w_busy;
  assign bus.done_o = r_done;
  assign bus.en_o   = r_en;
  assign bus.seg_o  = r_seg;

endmodule

// File: tb/tb_seg_value_encoder.sv
// Scoreboard bench for seg_value_encoder: each accepted load pushes the
// expected display and done_o time; a negedge monitor pops on done_o and
// otherwise checks that the display holds the last completed value.
module tb_seg_value_encoder;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  typedef struct {
    time         t;
    logic [3:0]  en;
    logic [31:0] seg;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic [3:0]  shown_en  = '0;
  logic [31:0] shown_seg = '0;

  seg_value_encoder_if #(.SEG_CNT(4), .VALUE_W(14)) bus ();

  seg_value_encoder #(.SEG_CNT(4), .VALUE_W(14)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input time t0, input logic [3:0] een, input logic [31:0] eseg);
    exp_t e;
    e.t   = t0 + 155;
    e.en  = een;
    e.seg = eseg;
    sb.push_back(e);
  endtask

  // Drive a one-cycle load starting just after a posedge
  task automatic do_load(input logic [13:0] v, input bit acc, input logic [3:0] een,
                         input logic [31:0] eseg);
    time t0;
    @(posedge clk);
    #1;
    bus.value_i = v;
    bus.load_i  = 1'b1;
    @(posedge clk);
    t0 = $time;
    #1;
    bus.load_i = 1'b0;
    if (acc) begin
      push_exp(t0, een, eseg);
      @(negedge clk);
      chk("busy_after_load", {63'd0, bus.busy_o}, 64'd1);
    end
  endtask

  // Load issued right now (used inside the done_o cycle)
  task automatic load_now(input logic [13:0] v, input logic [3:0] een, input logic [31:0] eseg);
    time t0;
    bus.value_i = v;
    bus.load_i  = 1'b1;
    @(posedge clk);
    t0 = $time;
    #1;
    bus.load_i = 1'b0;
    push_exp(t0, een, eseg);
    @(negedge clk);
    chk("busy_after_done_load", {63'd0, bus.busy_o}, 64'd1);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done_o) seen = 1'b1;
    end
    if (!seen) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: done_o not seen within 40 cycles", name);
    end
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_busy"}, {63'd0, bus.busy_o}, 64'd0);
    chk({tag, "_done"}, {63'd0, bus.done_o}, 64'd0);
    chk({tag, "_en"},   {60'd0, bus.en_o},   64'd0);
    chk({tag, "_seg"},  {32'd0, bus.seg_o},  64'd0);
  endtask

  // Monitor: pop on done_o, otherwise the display must hold
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.done_o) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_done: en=%b seg=%h with no pending load", bus.en_o, bus.seg_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (bus.en_o !== e.en || bus.seg_o !== e.seg) begin
            n_err++;
            $display("FAIL result: got en=%b seg=%h expected en=%b seg=%h",
                     bus.en_o, bus.seg_o, e.en, e.seg);
          end
          n_chk++;
          if ($time != e.t) begin
            n_err++;
            $display("FAIL latency: done at %0t expected %0t", $time, e.t);
          end
          shown_en  = e.en;
          shown_seg = e.seg;
        end
      end else begin
        n_chk++;
        if (bus.en_o !== shown_en || bus.seg_o !== shown_seg) begin
          n_err++;
          $display("FAIL hold: got en=%b seg=%h expected en=%b seg=%h",
                   bus.en_o, bus.seg_o, shown_en, shown_seg);
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    bus.load_i  = 1'b0;
    bus.value_i = '0;
    #2;
    chk_blank("reset_init");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_load(14'd1234, 1'b1, 4'b1111, 32'h065B4F66);
    wait_done("load_1234");

    // Asynchronous reset mid-cycle blanks the display at once
    @(posedge clk);
    #3;
    rst_n     = 1'b0;
    shown_en  = '0;
    shown_seg = '0;
    #1;
    chk_blank("reset_async");
    @(negedge clk);
    rst_n = 1'b1;

    do_load(14'd7, 1'b1, BLANK ? 4'b0001 : 4'b1111, BLANK ? 32'h00000007 : 32'h3F3F3F07);
    wait_done("load_7");
    do_load(14'd0, 1'b1, BLANK ? 4'b0001 : 4'b1111, BLANK ? 32'h0000003F : 32'h3F3F3F3F);
    wait_done("load_0");
    do_load(14'd10000, 1'b1, 4'b1111, 32'h40404040);
    wait_done("load_10000");
    do_load(14'd9999, 1'b1, 4'b1111, 32'h6F6F6F6F);
    wait_done("load_9999");
    do_load(14'd16383, 1'b1, 4'b1111, 32'h40404040);
    wait_done("load_16383");
    do_load(14'd5068, 1'b1, 4'b1111, 32'h6D3F7D7F);
    wait_done("load_5068");
    do_load(14'd800, 1'b1, BLANK ? 4'b0111 : 4'b1111, BLANK ? 32'h007F3F3F : 32'h3F7F3F3F);
    wait_done("load_800");

    // Load while busy is dropped; load in the done_o cycle is taken
    do_load(14'd42, 1'b1, BLANK ? 4'b0011 : 4'b1111, BLANK ? 32'h0000665B : 32'h3F3F665B);
    do_load(14'd99, 1'b0, 4'b0000, 32'h0);
    wait_done("load_42");
    load_now(14'd99, BLANK ? 4'b0011 : 4'b1111, BLANK ? 32'h00006F6F : 32'h3F3F6F6F);
    wait_done("load_99");

    // Reset during a conversion: no done_o, display blank
    do_load(14'd5678, 1'b0, 4'b0000, 32'h0);
    @(negedge clk);
    chk("busy_5678", {63'd0, bus.busy_o}, 64'd1);
    repeat (4) @(posedge clk);
    #2;
    rst_n     = 1'b0;
    shown_en  = '0;
    shown_seg = '0;
    #1;
    chk_blank("reset_conv");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_after_abort", {63'd0, bus.busy_o}, 64'd0);

    do_load(14'd9, 1'b1, BLANK ? 4'b0001 : 4'b1111, BLANK ? 32'h0000006F : 32'h3F3F3F6F);
    wait_done("load_9");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
